// File: rtl/riscv_pkg.sv
// RV32I/Zicsr encoding constants and the decode bundle shared by the ID stage.
package riscv_pkg;

  localparam int unsigned ILEN = 32;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_CSR   = 7'b1110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_LB     = 3'b000;
  localparam logic [2:0] F3_LH     = 3'b001;
  localparam logic [2:0] F3_LW     = 3'b010;
  localparam logic [2:0] F3_LBU    = 3'b100;
  localparam logic [2:0] F3_LHU    = 3'b101;
  localparam logic [2:0] F3_SB     = 3'b000;
  localparam logic [2:0] F3_SH     = 3'b001;
  localparam logic [2:0] F3_SW     = 3'b010;
  localparam logic [2:0] F3_BEQ    = 3'b000;
  localparam logic [2:0] F3_BNE    = 3'b001;
  localparam logic [2:0] F3_BLT    = 3'b100;
  localparam logic [2:0] F3_BGE    = 3'b101;
  localparam logic [2:0] F3_BLTU   = 3'b110;
  localparam logic [2:0] F3_BGEU   = 3'b111;
  localparam logic [2:0] F3_JALR   = 3'b000;
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_SHAMT,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_ZIMM
  } imm_type_e;

  // Imm is ILEN wide and sign-extended to XLEN by the consumer.
  typedef struct packed {
    logic            re1;
    logic            re2;
    logic            rd_we;
    logic            csr_we;
    logic [ILEN-1:0] imm;
    logic            illegal;
  } decode_t;

endpackage

// File: rtl/id_stage_if.sv
// IF/ID input, regfile/CSR/forwarding side-band and ID/EX output of the decode stage.
interface id_stage_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FWD = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic [XLEN-1:0]         in_pc;
  logic [31:0]             in_inst;
  logic                    flush;
  logic                    rs1_re;
  logic [4:0]              rs1_addr;
  logic [XLEN-1:0]         rs1_rdata;
  logic                    rs2_re;
  logic [4:0]              rs2_addr;
  logic [XLEN-1:0]         rs2_rdata;
  logic [NUM_FWD-1:0]      fwd_we;
  logic [NUM_FWD*5-1:0]    fwd_waddr;
  logic [NUM_FWD*XLEN-1:0] fwd_wdata;
  logic                    ex_ld_valid;
  logic [4:0]              ex_ld_rd;
  logic [11:0]             csr_raddr;
  logic [XLEN-1:0]         csr_rdata;
  logic                    out_valid;
  logic                    out_ready;
  logic [XLEN-1:0]         out_pc;
  logic [31:0]             out_inst;
  logic [XLEN-1:0]         out_rs1_val;
  logic [XLEN-1:0]         out_rs2_val;
  logic [XLEN-1:0]         out_imm;
  logic [XLEN-1:0]         out_csr_rdata;
  logic [4:0]              out_rd;
  logic                    out_rd_we;
  logic                    out_csr_we;
  logic [11:0]             out_csr_addr;
  logic                    out_illegal;

  modport master (
    output in_valid, in_pc, in_inst, flush, rs1_rdata, rs2_rdata,
           fwd_we, fwd_waddr, fwd_wdata, ex_ld_valid, ex_ld_rd, csr_rdata, out_ready,
    input  in_ready, rs1_re, rs1_addr, rs2_re, rs2_addr, csr_raddr,
           out_valid, out_pc, out_inst, out_rs1_val, out_rs2_val, out_imm,
           out_csr_rdata, out_rd, out_rd_we, out_csr_we, out_csr_addr, out_illegal
  );

  modport slave (
    input  in_valid, in_pc, in_inst, flush, rs1_rdata, rs2_rdata,
           fwd_we, fwd_waddr, fwd_wdata, ex_ld_valid, ex_ld_rd, csr_rdata, out_ready,
    output in_ready, rs1_re, rs1_addr, rs2_re, rs2_addr, csr_raddr,
           out_valid, out_pc, out_inst, out_rs1_val, out_rs2_val, out_imm,
           out_csr_rdata, out_rd, out_rd_we, out_csr_we, out_csr_addr, out_illegal
  );
endinterface

// File: rtl/id_decode.sv
// Combinational RV32I/Zicsr decoder: legality, register usage and immediate.
module id_decode
  import riscv_pkg::*;
(
  input  logic [31:0] inst,
  output decode_t     dec
);
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic            legal;
  logic            re1;
  logic            re2;
  logic            rd_we;
  logic            csr_we;
  imm_type_e       imm_type;
  logic [ILEN-1:0] imm;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign rd     = inst[11:7];

  // Classify opcode/funct3 into register usage and immediate format.
  always_comb begin
    legal    = 1'b0;
    re1      = 1'b0;
    re2      = 1'b0;
    rd_we    = 1'b0;
    csr_we   = 1'b0;
    imm_type = IMM_NONE;
    case (opcode)
      OP_R: begin
        legal = 1'b1;
        re1   = 1'b1;
        re2   = 1'b1;
        rd_we = 1'b1;
      end
      OP_I: begin
        legal    = 1'b1;
        re1      = 1'b1;
        rd_we    = 1'b1;
        imm_type = (funct3 == F3_SLL || funct3 == F3_SR) ? IMM_SHAMT : IMM_I;
      end
      OP_L: begin
        legal    = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        re1      = 1'b1;
        rd_we    = 1'b1;
        imm_type = IMM_I;
      end
      OP_S: begin
        legal    = funct3 inside {F3_SB, F3_SH, F3_SW};
        re1      = 1'b1;
        re2      = 1'b1;
        imm_type = IMM_S;
      end
      OP_B: begin
        legal    = funct3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU};
        re1      = 1'b1;
        re2      = 1'b1;
        imm_type = IMM_B;
      end
      OP_LUI, OP_AUIPC: begin
        legal    = 1'b1;
        rd_we    = 1'b1;
        imm_type = IMM_U;
      end
      OP_JAL: begin
        legal    = 1'b1;
        rd_we    = 1'b1;
        imm_type = IMM_J;
      end
      OP_JALR: begin
        legal    = (funct3 == F3_JALR);
        re1      = 1'b1;
        rd_we    = 1'b1;
        imm_type = IMM_I;
      end
      OP_CSR: begin
        if (funct3 inside {F3_CSRRW, F3_CSRRS, F3_CSRRC}) begin
          legal  = 1'b1;
          re1    = 1'b1;
          rd_we  = 1'b1;
          csr_we = 1'b1;
        end else if (funct3 inside {F3_CSRRWI, F3_CSRRSI, F3_CSRRCI}) begin
          legal    = 1'b1;
          rd_we    = 1'b1;
          csr_we   = 1'b1;
          imm_type = IMM_ZIMM;
        end
      end
      default: ;
    endcase
  end

  // Assemble the immediate for the selected format.
  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I:     imm = {{20{inst[31]}}, inst[31:20]};
      IMM_SHAMT: imm = {27'd0, inst[24:20]};
      IMM_S:     imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:     imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:     imm = {inst[31:12], 12'd0};
      IMM_J:     imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_ZIMM:  imm = {27'd0, inst[19:15]};
      default:   imm = '0;
    endcase
  end

  // An illegal instruction must not touch any architectural state.
  assign dec = '{
    re1:     legal & re1,
    re2:     legal & re2,
    rd_we:   legal & rd_we & (rd != 5'd0),
    csr_we:  legal & csr_we,
    imm:     legal ? imm : '0,
    illegal: ~legal
  };

endmodule

// File: rtl/id_stage.sv
// Decode stage: regfile read, forwarding, load-use stall and the ID/EX register.
module id_stage
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NUM_FWD  = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);
  localparam int unsigned REGW = 5;

  decode_t         dec;
  logic [REGW-1:0] rs1_addr;
  logic [REGW-1:0] rs2_addr;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm_ext;
  logic            stall;
  logic            advance;
  logic            accept;

  // Youngest matching forwarding source wins; x0 and unread operands are zero.
  function automatic logic [XLEN-1:0] fwd_pick(
    input logic                    re,
    input logic [REGW-1:0]         addr,
    input logic [XLEN-1:0]         rf,
    input logic [NUM_FWD-1:0]      we,
    input logic [NUM_FWD*REGW-1:0] wa,
    input logic [NUM_FWD*XLEN-1:0] wd
  );
    logic [XLEN-1:0] val;
    logic            hit;
    val = rf;
    hit = 1'b0;
    for (int unsigned i = 0; i < NUM_FWD; i++) begin
      if (!hit && we[i] && wa[i*REGW +: REGW] == addr) begin
        val = wd[i*XLEN +: XLEN];
        hit = 1'b1;
      end
    end
    if (!re || addr == '0) val = '0;
    return val;
  endfunction

  id_decode u_decode (
    .inst (bus.in_inst),
    .dec  (dec)
  );

  assign rs1_addr     = bus.in_inst[19:15];
  assign rs2_addr     = bus.in_inst[24:20];
  assign bus.rs1_addr = rs1_addr;
  assign bus.rs2_addr = rs2_addr;
  assign bus.rs1_re   = dec.re1;
  assign bus.rs2_re   = dec.re2;
  assign bus.csr_raddr = (bus.in_inst[6:0] == OP_CSR) ? bus.in_inst[31:20] : 12'd0;

  assign rs1_val = fwd_pick(dec.re1, rs1_addr, bus.rs1_rdata, bus.fwd_we, bus.fwd_waddr, bus.fwd_wdata);
  assign rs2_val = fwd_pick(dec.re2, rs2_addr, bus.rs2_rdata, bus.fwd_we, bus.fwd_waddr, bus.fwd_wdata);
  assign imm_ext = XLEN'($signed(dec.imm));

  // Load in EX whose result this instruction needs cannot be forwarded yet.
  assign stall = bus.ex_ld_valid && (bus.ex_ld_rd != '0) &&
                 ((dec.re1 && rs1_addr == bus.ex_ld_rd) || (dec.re2 && rs2_addr == bus.ex_ld_rd));

  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !bus.flush && !stall && advance;
  assign accept       = bus.in_valid && bus.in_ready;

  // ID/EX register: reset, flush, load/bubble when EX drains, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid     <= 1'b0;
      bus.out_pc        <= RESET_PC;
      bus.out_inst      <= '0;
      bus.out_rs1_val   <= '0;
      bus.out_rs2_val   <= '0;
      bus.out_imm       <= '0;
      bus.out_csr_rdata <= '0;
      bus.out_rd        <= '0;
      bus.out_rd_we     <= 1'b0;
      bus.out_csr_we    <= 1'b0;
      bus.out_csr_addr  <= '0;
      bus.out_illegal   <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (advance) begin
      bus.out_valid <= accept;
      if (accept) begin
        bus.out_pc        <= bus.in_pc;
        bus.out_inst      <= bus.in_inst;
        bus.out_rs1_val   <= rs1_val;
        bus.out_rs2_val   <= rs2_val;
        bus.out_imm       <= imm_ext;
        bus.out_csr_rdata <= bus.csr_rdata;
        bus.out_rd        <= bus.in_inst[11:7];
        bus.out_rd_we     <= dec.rd_we;
        bus.out_csr_we    <= dec.csr_we;
        bus.out_csr_addr  <= dec.csr_we ? bus.in_inst[31:20] : 12'd0;
        bus.out_illegal   <= dec.illegal;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed and randomized checks of id_stage against a behavioural model.
module tb_id_stage;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned NF     = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0080;

  typedef struct packed {
    logic        legal;
    logic        re1;
    logic        re2;
    logic        rd_we;
    logic        csr_we;
    logic        has_imm;
    logic [31:0] imm;
  } ref_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic        m_valid;
  logic        m_full;
  logic [31:0] m_pc, m_inst, m_rs1, m_rs2, m_csr;
  ref_t        m_dec;

  id_stage_if #(.XLEN(XLEN), .NUM_FWD(NF)) bus ();

  id_stage #(.XLEN(XLEN), .NUM_FWD(NF), .RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decode written from the ISA tables with arithmetic field extraction.
  function automatic ref_t ref_decode(input logic [31:0] w);
    ref_t        r;
    logic [2:0]  f3;
    logic [31:0] sgn;
    r   = '0;
    f3  = w[14:12];
    sgn = 32'($signed(w) >>> 31);
    case (w[6:0])
      7'h33: begin r.legal = 1; r.re1 = 1; r.re2 = 1; r.rd_we = 1; end
      7'h13: begin
        r.legal = 1; r.re1 = 1; r.rd_we = 1; r.has_imm = 1;
        r.imm = (f3 == 3'd1 || f3 == 3'd5) ? 32'(w[24:20]) : 32'($signed(w) >>> 20);
      end
      7'h03: begin
        r.legal = (f3 != 3'd3) && (f3 <= 3'd5); r.re1 = 1; r.rd_we = 1; r.has_imm = 1;
        r.imm = 32'($signed(w) >>> 20);
      end
      7'h23: begin
        r.legal = (f3 <= 3'd2); r.re1 = 1; r.re2 = 1; r.has_imm = 1;
        r.imm = (32'($signed(w) >>> 25) << 5) | 32'(w[11:7]);
      end
      7'h63: begin
        r.legal = (f3 != 3'd2) && (f3 != 3'd3); r.re1 = 1; r.re2 = 1; r.has_imm = 1;
        r.imm = (sgn << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      end
      7'h37, 7'h17: begin
        r.legal = 1; r.rd_we = 1; r.has_imm = 1; r.imm = w & 32'hFFFF_F000;
      end
      7'h6F: begin
        r.legal = 1; r.rd_we = 1; r.has_imm = 1;
        r.imm = (sgn << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      end
      7'h67: begin
        r.legal = (f3 == 3'd0); r.re1 = 1; r.rd_we = 1; r.has_imm = 1;
        r.imm = 32'($signed(w) >>> 20);
      end
      7'h73: begin
        r.legal = (f3 != 3'd0) && (f3 != 3'd4); r.rd_we = 1; r.csr_we = 1;
        r.re1 = (f3 < 3'd4);
        r.has_imm = (f3 > 3'd4);
        r.imm = r.has_imm ? 32'(w[19:15]) : 32'd0;
      end
      default: ;
    endcase
    if (!r.legal) r = '0;
    if (w[11:7] == 5'd0) r.rd_we = 0;
    return r;
  endfunction

  function automatic logic [31:0] ref_operand(input logic re, input logic [4:0] a, input logic [31:0] rf);
    logic [31:0] v;
    logic        found;
    v = rf;
    found = 0;
    for (int i = 0; i < NF; i++) begin
      if (!found && bus.fwd_we[i] && bus.fwd_waddr[i*5 +: 5] == a) begin
        v = bus.fwd_wdata[i*32 +: 32];
        found = 1;
      end
    end
    if (!re || a == 5'd0) v = 32'd0;
    return v;
  endfunction

  task automatic set_idle();
    bus.in_valid    = 0;
    bus.in_pc       = 32'd0;
    bus.in_inst     = 32'h0000_0013;
    bus.flush       = 0;
    bus.rs1_rdata   = 32'd0;
    bus.rs2_rdata   = 32'd0;
    bus.fwd_we      = '0;
    bus.fwd_waddr   = '0;
    bus.fwd_wdata   = '0;
    bus.ex_ld_valid = 0;
    bus.ex_ld_rd    = 5'd0;
    bus.csr_rdata   = 32'd0;
    bus.out_ready   = 1;
  endtask

  // One clock: check combinational outputs, step the model, check the register.
  task automatic cycle();
    ref_t        d;
    logic        stall_m, rdy_m, acc;
    logic [31:0] w;
    @(negedge clk);
    w = bus.in_inst;
    d = ref_decode(w);
    check("rs1_re", 64'(bus.rs1_re), 64'(d.re1));
    check("rs2_re", 64'(bus.rs2_re), 64'(d.re2));
    check("rs1_addr", 64'(bus.rs1_addr), 64'(w[19:15]));
    check("rs2_addr", 64'(bus.rs2_addr), 64'(w[24:20]));
    check("csr_raddr", 64'(bus.csr_raddr), (w[6:0] == 7'h73) ? 64'(w[31:20]) : 64'd0);
    stall_m = bus.ex_ld_valid && bus.ex_ld_rd != 5'd0 &&
              ((d.re1 && w[19:15] == bus.ex_ld_rd) || (d.re2 && w[24:20] == bus.ex_ld_rd));
    rdy_m = !bus.flush && !stall_m && (!m_valid || bus.out_ready);
    if (!rst) check("in_ready", 64'(bus.in_ready), 64'(rdy_m));
    m_full = 0;
    if (rst) begin
      m_valid = 0;
      m_full  = 1;
    end else if (bus.flush) begin
      m_valid = 0;
    end else if (!m_valid || bus.out_ready) begin
      acc     = bus.in_valid && rdy_m;
      m_valid = acc;
      if (acc) begin
        m_pc   = bus.in_pc;
        m_inst = w;
        m_rs1  = ref_operand(d.re1, w[19:15], bus.rs1_rdata);
        m_rs2  = ref_operand(d.re2, w[24:20], bus.rs2_rdata);
        m_csr  = bus.csr_rdata;
        m_dec  = d;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", 64'(bus.out_valid), 64'(m_valid));
    if (m_full) begin
      check("rst_pc", 64'(bus.out_pc), 64'(RST_PC));
      check("rst_fields", 64'({bus.out_inst, bus.out_rd, bus.out_rd_we, bus.out_csr_we,
                               bus.out_csr_addr, bus.out_illegal}), 64'd0);
      check("rst_data", 64'(bus.out_rs1_val | bus.out_rs2_val | bus.out_imm | bus.out_csr_rdata), 64'd0);
    end else if (m_valid) begin
      check("out_pc", 64'(bus.out_pc), 64'(m_pc));
      check("out_inst", 64'(bus.out_inst), 64'(m_inst));
      check("out_rs1_val", 64'(bus.out_rs1_val), 64'(m_rs1));
      check("out_rs2_val", 64'(bus.out_rs2_val), 64'(m_rs2));
      check("out_csr_rdata", 64'(bus.out_csr_rdata), 64'(m_csr));
      check("out_illegal", 64'(bus.out_illegal), 64'(!m_dec.legal));
      check("out_rd_we", 64'(bus.out_rd_we), 64'(m_dec.rd_we));
      check("out_csr_we", 64'(bus.out_csr_we), 64'(m_dec.csr_we));
      if (m_dec.legal) check("out_rd", 64'(bus.out_rd), 64'(m_inst[11:7]));
      if (m_dec.has_imm) check("out_imm", 64'(bus.out_imm), 64'(m_dec.imm));
      if (m_dec.csr_we) check("out_csr_addr", 64'(bus.out_csr_addr), 64'(m_inst[31:20]));
    end
  endtask

  task automatic rand_inputs();
    logic [6:0]  ops [12];
    logic [31:0] w;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h73, 7'h7F, 7'h0B};
    w = $urandom;
    w[6:0]   = ops[$urandom_range(0, 11)];
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    bus.in_inst     = w;
    bus.in_pc       = $urandom & 32'hFFFF_FFFC;
    bus.in_valid    = ($urandom_range(0, 9) < 8);
    bus.out_ready   = ($urandom_range(0, 3) != 0);
    bus.flush       = ($urandom_range(0, 19) == 0);
    bus.rs1_rdata   = $urandom;
    bus.rs2_rdata   = $urandom;
    bus.csr_rdata   = $urandom;
    bus.fwd_we      = 2'($urandom_range(0, 3));
    bus.fwd_waddr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    bus.fwd_wdata   = {$urandom, $urandom};
    bus.ex_ld_valid = ($urandom_range(0, 4) == 0);
    bus.ex_ld_rd    = 5'($urandom_range(0, 7));
    rst             = ($urandom_range(0, 99) == 0);
  endtask

  initial begin
    m_valid = 0;
    m_full  = 0;
    m_pc = '0; m_inst = '0; m_rs1 = '0; m_rs2 = '0; m_csr = '0; m_dec = '0;
    set_idle();
    rst = 1;
    cycle();
    cycle();
    rst = 0;

    // ADDI x1,x0,5
    bus.in_valid = 1; bus.in_pc = 32'h100; bus.in_inst = 32'h0050_0093;
    cycle();
    check("addi_imm", 64'(bus.out_imm), 64'd5);
    check("addi_rd", 64'(bus.out_rd), 64'd1);
    check("addi_rs1", 64'(bus.out_rs1_val), 64'd0);

    // ADD x3,x1,x2 with two sources forwarding x1
    bus.in_pc = 32'h104; bus.in_inst = 32'h0020_81B3;
    bus.fwd_we = 2'b11; bus.fwd_waddr = {5'd1, 5'd1}; bus.fwd_wdata = {32'h22, 32'h11};
    bus.rs2_rdata = 32'h7;
    cycle();
    check("fwd_youngest", 64'(bus.out_rs1_val), 64'h11);
    check("fwd_rs2_rf", 64'(bus.out_rs2_val), 64'h7);

    // Load-use: ADD x6,x5,x0 behind a load to x5
    bus.fwd_we = '0; bus.in_pc = 32'h108; bus.in_inst = 32'h0002_8333;
    bus.ex_ld_valid = 1; bus.ex_ld_rd = 5'd5;
    cycle();
    check("lu_bubble", 64'(bus.out_valid), 64'd0);
    bus.ex_ld_valid = 0;
    cycle();
    check("lu_issue", 64'(bus.out_inst), 64'h0002_8333);

    // Backpressure for three cycles
    bus.in_pc = 32'h10C; bus.in_inst = 32'h0010_0493; bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_hold", 64'(bus.out_inst), 64'h0002_8333);
    end
    bus.out_ready = 1;
    cycle();
    check("bp_resume", 64'(bus.out_inst), 64'h0010_0493);

    // Flush beats an incoming instruction
    bus.flush = 1; bus.in_inst = 32'h0000_0433;
    cycle();
    check("flush_drop", 64'(bus.out_valid), 64'd0);
    bus.flush = 0;

    // Forwarding to x0 is ignored
    bus.fwd_we = 2'b01; bus.fwd_waddr = {5'd0, 5'd0}; bus.fwd_wdata = {32'd0, 32'hFF};
    bus.rs1_rdata = 32'h55; bus.rs2_rdata = 32'h66;
    cycle();
    check("x0_rs1", 64'(bus.out_rs1_val), 64'd0);
    check("x0_rs2", 64'(bus.out_rs2_val), 64'd0);
    bus.fwd_we = '0;

    // Illegal opcode and illegal branch funct3
    bus.in_inst = 32'h0000_007F;
    cycle();
    check("ill_op", 64'({bus.out_illegal, bus.out_rd_we}), 64'b10);
    bus.in_inst = 32'h0011_2063;
    cycle();
    check("ill_beq", 64'({bus.out_illegal, bus.out_rd_we}), 64'b10);

    // CSRRWI x1, 0x300, 3
    bus.in_inst = 32'h3001_D0F3; bus.csr_rdata = 32'hABCD;
    cycle();
    check("csri_imm", 64'(bus.out_imm), 64'd3);
    check("csri_we", 64'(bus.out_csr_we), 64'd1);
    check("csri_addr", 64'(bus.out_csr_addr), 64'h300);

    // Reset in the middle of a load-use stall
    bus.in_inst = 32'h0002_8333; bus.ex_ld_valid = 1; bus.ex_ld_rd = 5'd5;
    cycle();
    rst = 1;
    cycle();
    rst = 0; bus.ex_ld_valid = 0;
    cycle();
    check("post_rst_issue", 64'(bus.out_valid), 64'd1);

    for (int n = 0; n < 800; n++) begin
      rand_inputs();
      cycle();
    end
    rst = 0;
    set_idle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Parametrised RV32I/Zicsr decode stage with a registered ID/EX pipeline register.
- Decodes the instruction from IF/ID and reads the register file.
- Resolves operands through an N-source forwarding network with youngest-wins priority.
- Detects load-use hazards, inserts bubbles, honours flush, and hands off to EX over a valid/ready handshake.

Parameters:
XLEN, 32, data/address width
NUM_FWD, 2, number of forwarding sources; index 0 = youngest (EX), index NUM_FWD-1 = oldest
RESET_PC, 0, value driven on out_pc during reset

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  IF/ID holds an instruction
in_ready  out  1  stage accepts the instruction this cycle
in_pc  in  XLEN  instruction address
in_inst  in  32  instruction word
flush  in  1  kill the held instruction and the incoming instruction (branch/trap)
rs1_re  out  1  regfile read enable 1
rs1_addr  out  5  regfile read address 1 (inst[19:15])
rs1_rdata  in  XLEN  regfile data 1
rs2_re  out  1  regfile read enable 2
rs2_addr  out  5  regfile read address 2 (inst[24:20])
rs2_rdata  in  XLEN  regfile data 2
fwd_we  in  NUM_FWD  per-source write enable
fwd_waddr  in  NUM_FWD*5  per-source destination, packed
fwd_wdata  in  NUM_FWD*XLEN  per-source data, packed
ex_ld_valid  in  1  instruction in EX is a load
ex_ld_rd  in  5  destination of that load
csr_raddr  out  12  CSR read address (inst[31:20])
csr_rdata  in  XLEN  CSR read data, combinational
out_valid  out  1  ID/EX register holds an instruction
out_ready  in  1  EX accepts
out_pc, out_inst  out  XLEN, 32  registered pc/inst
out_rs1_val, out_rs2_val  out  XLEN  resolved operands
out_imm  out  XLEN  decoded immediate
out_csr_rdata  out  XLEN  captured CSR value
out_rd  out  5  destination register
out_rd_we  out  1  destination write enable
out_csr_we  out  1  CSR write enable
out_csr_addr  out  12  CSR write address
out_illegal  out  1  undecodable instruction

Behaviour:
- Decode is combinational on in_inst.
  - Immediates: I/S/B/U/J formats, sign-extended to XLEN.
  - Shift-immediate: shamt zero-extended.
  - CSR*I: zimm (inst[19:15]) zero-extended into out_imm.
- Read enables:
  - R/S/B: rs1 and rs2.
  - I/L/JALR/CSR(reg): rs1 only.
  - LUI/AUIPC/JAL/CSR*I: none.
- rd_we:
  - Set for R/I/L/LUI/AUIPC/JAL/JALR/CSR.
  - Clear for S/B.
  - Forced 0 when rd=0.
- JALR writes rd (link).
- Illegal instruction: unknown opcode or funct3 gives out_illegal=1, with rd_we, csr_we and read enables all 0.
- Operand resolution, per operand:
  - Read disabled: 0.
  - Address 0: 0. x0 never forwards.
  - Otherwise, the lowest index i with fwd_we[i] && fwd_waddr[i]==addr supplies the data.
  - If no source matches: regfile data.
- stall = ex_ld_valid && ex_ld_rd!=0 && ((rs1_re && rs1_addr==ex_ld_rd) || (rs2_re && rs2_addr==ex_ld_rd)).
- in_ready = !flush && !stall && (!out_valid || out_ready).
- Register update, in priority order:
  1. rst: all out_* = 0, out_pc = RESET_PC.
  2. flush: out_valid <= 0. Other fields are don't-care.
  3. (!out_valid || out_ready):
     - in_valid && in_ready: load the register, out_valid <= 1.
     - Else (stall or no input): out_valid <= 0, i.e. a bubble.
  4. Else: hold all fields; no change on backpressure.
- Latency: one cycle from acceptance to out_valid.
- Throughput: one instruction per cycle without hazards.
- A load-use hazard costs exactly one bubble, provided EX clears ex_ld_valid after its load advances.
- Flush in the same cycle as out_ready or in_valid: flush wins, nothing is accepted.
- Reset mid-stall: the register clears and the next cycle has no bubble dependency.
- csr_raddr is driven from inst[31:20] for CSR opcodes, else 0.
- out_csr_addr/out_csr_we are set for all six CSR forms.

Decomposition:
- Package riscv_pkg:
  - opcode constants (OP_R, OP_I, OP_S, OP_B, OP_L, OP_CSR, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR);
  - FUNC3 constants;
  - imm_type enum;
  - decode struct (re1, re2, rd_we, csr_we, imm, illegal).
- One combinational sub-module, id_decode: inst in, decode struct out.
- Forwarding muxes and the pipeline register stay in id_stage.

Test Plan:
- ADDI x1,x0,5 with fwd_we=0, out_ready=1 -> next cycle out_valid=1, out_imm=5, out_rd=1, out_rd_we=1, out_rs1_val=0.
- ADD x3,x1,x2; fwd0 (x1,0x11), fwd1 (x1,0x22) both valid; rs2_rdata=0x7 -> out_rs1_val=0x11 (youngest wins), out_rs2_val=0x7.
- ex_ld_valid=1, ex_ld_rd=5, in_inst=ADD x6,x5,x0 -> in_ready=0, one bubble (out_valid=0); ex_ld_valid drops next cycle -> instruction issued.
- out_ready=0 for 3 cycles while out_valid=1 -> all out_* stable, in_ready=0; resumes on out_ready=1.
- flush with in_valid=1 and valid held instruction -> next cycle out_valid=0, instruction dropped; fwd to x0 (fwd_waddr=0, data 0xFF) -> operand reads 0.
- Opcode 0x7F, and BEQ with funct3=010 -> out_illegal=1, out_rd_we=0; CSRRWI 0x300, zimm=3 -> csr_raddr=0x300, out_imm=3, out_csr_we=1.
